// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
// Single-clock FIFO controller. Storage is a register array of 2^ADDR_WIDTH
// words. The block tracks occupancy, decodes full/empty and the programmable
// almost-full/almost-empty thresholds from the count register, and keeps
// sticky overflow/underflow error flags.
//
// Optional build macro: FIFO_FWFT_EN
//   undefined : standard mode, rd_data/rd_valid registered one cycle after a pop
//   defined   : first-word-fall-through, head word visible combinationally
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   wr_en/wr_data write request and word
//   rd_en         read request (pop / acknowledge in FWFT mode)
//   rd_data       read word
//   rd_valid      rd_data holds a valid word
//   full, almost_full, empty, almost_empty  occupancy flags
//   count         occupancy 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   clr_err       clears overflow/underflow (a new error the same cycle wins)
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_accept, rd_accept;

  // Flags decode the registered count, so they follow an operation by one cycle.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_CNT);
  assign almost_empty = (count_q <= AEMPTY_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // A write while full and a read while empty are rejected outright; there is
    // no pass-through or bypass path between the two ports.
    wr_accept = wr_en && !full;
    rd_accept = rd_en && !empty;

    wr_ptr_d = wr_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;

    rd_ptr_d = rd_ptr_q;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first, then set, so an error in the clearing cycle survives.
    overflow_d = overflow_q;
    if (clr_err) overflow_d = 1'b0;
    if (wr_en && full) overflow_d = 1'b1;

    underflow_d = underflow_q;
    if (clr_err) underflow_d = 1'b0;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; rd_en only acknowledges it. Forced to zero
  // while empty so the output is deterministic after reset.
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_accept) rd_data_d = mem_q[rd_ptr_q];
    rd_valid_d = rd_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl
// Scoreboard bench for sync_fifo_ctrl. Written words are queued as they are
// driven; each accepted pop removes the expected word, which is then compared
// with what the DUT presents (next cycle in standard mode, same cycle with
// FIFO_FWFT_EN defined).
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 64;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic       almost_empty;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  sync_fifo_ctrl #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (6),
    .AFULL_THRESH (56),
    .AEMPTY_THRESH(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  // Reference model state
  logic [7:0] sb_q[$];
  int         m_count;
  bit         m_ov;
  bit         m_un;
  bit         m_rd_acc;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic [7:0] got_data;
  logic       got_valid;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  // Reset the DUT for n cycles and clear the model.
  task automatic do_reset(input int n);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_count = 0; m_ov = 1'b0; m_un = 1'b0;
  endtask

  // Drive one cycle of stimulus and advance the model. Leaves got_* / exp_*
  // describing the read side of that cycle for the caller to compare.
  task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit c);
    bit m_wr_acc;
    wr_en = w; wr_data = wd; rd_en = r; clr_err = c;
    m_wr_acc = w && (m_count != DEPTH);
    m_rd_acc = r && (m_count != 0);
    if (m_rd_acc) exp_data = sb_q.pop_front();
    if (m_wr_acc) sb_q.push_back(wd);
    if (FWFT) begin
      #1;
      got_valid = rd_valid;
      got_data  = rd_data;
      exp_valid = (m_count != 0);
    end
    if (w && m_count == DEPTH) m_ov = 1'b1;
    else if (c)                m_ov = 1'b0;
    if (r && m_count == 0)     m_un = 1'b1;
    else if (c)                m_un = 1'b0;
    if (m_wr_acc && !m_rd_acc)      m_count++;
    else if (m_rd_acc && !m_wr_acc) m_count--;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    if (!FWFT) begin
      got_valid = rd_valid;
      got_data  = rd_data;
      exp_valid = m_rd_acc;
    end
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks++;
    if ({empty, full, almost_empty, almost_full, rd_valid, overflow, underflow} !== 7'b1010000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b required %b",
               {empty, full, almost_empty, almost_full, rd_valid, overflow, underflow}, 7'b1010000);
    end
    n_checks++;
    if (count !== 7'd0) begin
      n_fail++; $display("[TB] FAIL reset_count: got %0d required 0", count);
    end
    n_checks++;
    if (rd_data !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_rd_data: got %h required 00", rd_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (count !== 7'(m_count) || almost_full !== (m_count >= 56) ||
          full !== (m_count == DEPTH) || empty !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL fill_status[%0d]: got count=%0d af=%b f=%b e=%b required count=%0d af=%b f=%b e=0",
                 i, count, almost_full, full, empty, m_count, (m_count >= 56), (m_count == DEPTH));
      end
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 7'd64 || full !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fill_overflow: got ov=%b count=%0d full=%b required ov=1 count=64 full=1",
               overflow, count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (got_valid !== exp_valid || got_data !== exp_data || exp_data !== 8'(i)) begin
        n_fail++;
        $display("[TB] FAIL drain_data[%0d]: got valid=%b data=%h required valid=%b data=%h",
                 i, got_valid, got_data, exp_valid, 8'(i));
      end
      n_checks++;
      if (almost_empty !== (m_count <= 8) || empty !== (m_count == 0)) begin
        n_fail++;
        $display("[TB] FAIL drain_flags[%0d]: got ae=%b e=%b required ae=%b e=%b",
                 i, almost_empty, empty, (m_count <= 8), (m_count == 0));
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (underflow !== 1'b1 || got_valid !== 1'b0 || count !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL drain_underflow: got un=%b valid=%b count=%0d required un=1 valid=0 count=0",
               underflow, got_valid, count);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Move both pointers to 50 so the simultaneous phase crosses 63 -> 0.
    fill(50, 8'h80);
    drain(50);
    fill(10, 8'h10);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
      n_checks++;
      if (count !== 7'd10 || got_valid !== exp_valid || got_data !== exp_data) begin
        n_fail++;
        $display("[TB] FAIL wrap_rw[%0d]: got count=%0d valid=%b data=%h required count=10 valid=%b data=%h",
                 i, count, got_valid, got_data, exp_valid, exp_data);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (got_data !== exp_data || exp_data !== 8'h4A + 8'(i)) begin
        n_fail++;
        $display("[TB] FAIL wrap_tail[%0d]: got %h required %h", i, got_data, 8'h4A + 8'(i));
      end
    end
  endtask

  task automatic test_simul_full_empty();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    fill(DEPTH, 8'hC0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    n_checks++;
    if (count !== 7'd63 || overflow !== 1'b1 || got_data !== 8'hC0) begin
      n_fail++;
      $display("[TB] FAIL rw_at_full: got count=%0d ov=%b data=%h required count=63 ov=1 data=c0",
               count, overflow, got_data);
    end
    drain(63);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    n_checks++;
    if (count !== 7'd1 || underflow !== 1'b1 || got_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rw_at_empty: got count=%0d un=%b valid=%b required count=1 un=1 valid=0",
               count, underflow, got_valid);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (got_data !== 8'h77 || got_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rw_empty_word: got valid=%b data=%h required valid=1 data=77", got_valid, got_data);
    end
  endtask

  task automatic test_clr_err();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_both: got ov=%b un=%b required ov=0 un=0", overflow, underflow);
    end
    fill(DEPTH, 8'h00);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clr_overflow: got %b required 0", overflow);
    end
    step(1'b1, 8'h33, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1 || overflow !== m_ov) begin
      n_fail++; $display("[TB] FAIL clr_set_wins_ov: got %b required 1", overflow);
    end
    drain(DEPTH);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (underflow !== 1'b1) begin
      n_fail++; $display("[TB] FAIL clr_set_wins_un: got %b required 1", underflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clr_underflow: got %b required 0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    fill(30, 8'h20);
    n_checks++;
    if (count !== 7'd30) begin
      n_fail++; $display("[TB] FAIL mid_pre_count: got %0d required 30", count);
    end
    do_reset(1);
    n_checks++;
    if (count !== 7'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got count=%0d e=%b valid=%b data=%h required count=0 e=1 valid=0 data=00",
               count, empty, rd_valid, rd_data);
    end
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (got_valid !== 1'b1 || got_data !== 8'h5C) begin
      n_fail++;
      $display("[TB] FAIL mid_roundtrip: got valid=%b data=%h required valid=1 data=5c", got_valid, got_data);
    end
    n_checks++;
    if (sb_q.size() != 0 || count !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_final_count: got count=%0d required 0", count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    $display("[TB] sync_fifo_ctrl bench, fwft=%0d", FWFT);
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_full_empty();
    test_clr_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's async FIFO and targets same-domain buffering between the transaction generator/driver-side RTL and the DUT datapath. Adds over the previous block: occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with clear, and an optional first-word-fall-through read mode. Storage is an inferred register array of 2^ADDR_WIDTH words.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 6, log2 of depth; DEPTH = 2^ADDR_WIDTH (64 by default)
AFULL_THRESH, 56, almost_full asserted when count >= this value; legal range 1..DEPTH
AEMPTY_THRESH, 8, almost_empty asserted when count <= this value; legal range 0..DEPTH-1

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request (pop)
rd_data  out  DATA_WIDTH  read word, registered
rd_valid  out  1  rd_data holds a freshly popped word
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_THRESH
empty  out  1  count == 0
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty
clr_err  in  1  clears overflow and underflow

Behaviour:
- Reset is synchronous and active-high (rst sampled on clk rising edge). While rst=1: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset. Reset mid-operation discards all stored words; the first write after rst deasserts is stored at address 0.
- Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally. Full/empty are decoded from the count register, not from pointer comparison.
- Accepted write: wr_en && !full. Stores wr_data at wr_ptr, then wr_ptr+1.
- Accepted read: rd_en && !empty. Pops the word at rd_ptr, then rd_ptr+1.
- Standard mode: rd_data is registered with the popped word and rd_valid=1 on the cycle after an accepted read (1-cycle latency). rd_valid=0 on cycles following a non-accepted read. rd_data holds its last value otherwise.
- count next value: +1 on write only, -1 on read only, unchanged on both or neither. All flags are combinational decodes of the registered count, so they change the cycle after the causing operation.
- Simultaneous rd_en/wr_en:
  - When full: the read is accepted; the write is rejected and overflow is set (no pass-through).
  - When empty: the write is accepted; the read is rejected and underflow is set (no bypass).
  - Otherwise: both are accepted and count is unchanged.
- Errors: overflow is set by wr_en && full; underflow is set by rd_en && empty. Rejected operations leave pointers, count and memory untouched. clr_err clears both flags on the next edge; if a new error occurs in the same cycle, set wins.

Optional Feature:
FIFO_FWFT_EN. When defined, the block runs in first-word-fall-through mode:
- rd_data presents the head word combinationally from memory at rd_ptr.
- rd_valid equals !empty.
- rd_en acts as an acknowledge that pops the head; the next word appears in the same cycle the pointer advances. Read latency is 0.
- All count, flag and error rules are unchanged.
When the macro is undefined, the standard registered 1-cycle read mode described above applies.

Test Plan:
- Reset, then write 0x00..0x3F on 64 consecutive cycles -> count=64, full=1, almost_full=1 (from count 56), empty=0; the 65th write (0xAA) is dropped, overflow=1, count stays 64.
- From full, read 64 cycles -> rd_data 0x00..0x3F in order, each with rd_valid=1 one cycle later; then empty=1, almost_empty=1 from count 8; one further rd_en gives underflow=1, rd_valid=0.
- Fill to count=10, then 20 cycles of simultaneous rd/wr -> count holds 10 and data order is preserved across the pointer wrap at 63->0.
- At full, assert rd_en and wr_en together -> read accepted, write rejected, count=63, overflow=1. At empty, assert both -> write accepted, count=1, underflow=1.
- overflow=1, then pulse clr_err with no error -> overflow=0. Pulse clr_err together with a write-while-full -> overflow remains 1.
- At count=30, assert rst for 1 cycle -> count=0, empty=1, rd_valid=0; the next write/read round-trips 0x5C correctly. Repeat the full suite with FIFO_FWFT_EN defined, expecting 0-cycle read latency.
